accumulation_control: RTL and testbench
=======================================

# accumulation_control

Downstream stage of the adder-tree datapath (multiplier → addertree_stage1/2/3 → adder_final). It consumes the 14-bit `adder_final` sum and saturates it to the 13-bit accumulator range. It feeds the registered partial sum back as `pre_output` into `addertree_stage2` over a configurable number of channel passes. At the end of each window it applies ReLU/requantization and emits one 8-bit result through a 2-entry valid/ready output buffer.

## Interface
- `PASS_W`, 4, width of pass counter / `cfg_passes`
- `OUT_W`, 8, output data width (signed)
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low (0 = reset)
- `cfg_passes` in PASS_W: passes per window, 1..15; 0 treated as 1
- `cfg_shift` in 4: requant arithmetic right shift, 0..12
- `cfg_relu` in 1: 1 = clamp negatives to 0
- `in_valid` in 1: `in_sum` valid this cycle
- `in_ready` out 1: input accepted when `in_valid & in_ready`
- `in_sum` in 14: `adder_final` output; [13:12] are guard bits
- `pre_output` out 13: signed partial sum fed back to `addertree_stage2`
- `out_valid` out 1: `out_data` valid
- `out_ready` in 1: consumer accepts
- `out_data` out OUT_W: signed result
- `busy` out 1: window open or buffer non-empty

## Operation
- Saturation `sat(in_sum)`:
  - [13:12]=01 → +4095.
  - [13:12]=10 → −4096.
  - Otherwise [12:0].
- FSM:
  - IDLE: `pass_cnt`=0, no window open.
  - ACCUM: window open.
  - IDLE→ACCUM on an accepted non-final input. ACCUM→IDLE on an accepted final input.
- Config latch: `cfg_*` are latched on the first accepted input of a window (`pass_cnt`=0). Changes mid-window are ignored.
- Final pass: `pass_cnt == passes_l−1`. With passes=1, every input is final; the FSM stays in IDLE.
- Non-final accept: `pre_output` ← sat, `pass_cnt`++.
- Final accept: `pre_output` ← 0, `pass_cnt` ← 0, push `rq(sat)` into the buffer.
- `rq(s)`:
  - If `relu_l` and s<0, s=0.
  - If `shift_l`>0, add 1<<(`shift_l`−1) (round half up); then arithmetic shift right by `shift_l`.
  - Saturate to [−128, 127].
  - Intermediate width 14 bits signed.
- `in_ready`: 1 on non-final passes; on the final pass, `in_ready` = buffer not full.
- Output buffer: 2-entry FIFO, in-order.
  - `out_data` is the head entry.
  - Pop on `out_valid & out_ready`.
  - Push and pop in the same cycle are legal at count 1.
  - Push at count 2 is impossible by `in_ready`.
- `busy` = (state==ACCUM) | (count≠0).

## Timing
- Reset values: `pre_output`=0, `out_valid`=0, `out_data`=0, `busy`=0, `pass_cnt`=0, FSM=IDLE, FIFO empty.
- `in_ready` after reset is 1. It is combinational from `pass_cnt`/count and has no path from `out_ready`.
- `pre_output` is registered. The upstream tree combines it with the next `in_sum` combinationally in the following cycle.
- Latency: a final input accepted at edge t gives `out_valid`=1 after edge t, with the data visible from cycle t+1.
- Throughput: 1 input/cycle. An output stream sustains 1/cycle when `out_ready`=1.
- `in_valid`=0 holds all state. A window may stall indefinitely between passes.
- Reset asserted mid-window or with a non-empty buffer: the window is aborted and buffered results are discarded. The next accepted input is pass 0.

## Structure
- Package `npu_acc_pkg`:
  - `SUM_W`=14, `ACC_W`=13, `ACC_MAX`=4095, `ACC_MIN`=−4096.
  - FSM enum {IDLE, ACCUM}.
  - Function `sat14to13`.
- Sub-module `acc_out_fifo`: 2-entry valid/ready FIFO, parameterized on width. It owns `out_valid`, `out_data` and `full`.
- Top holds the FSM, pass counter, config latch, saturation, requant and `pre_output` register.

## Test plan
- passes=1, shift=0, relu=0, `in_sum`=256 → `out_data`=127, one cycle later. Same input with shift=2 → 64. `pre_output` stays 0.
- passes=3, `in_sum` 100, 200, 300 on consecutive cycles → `pre_output` reads 0, 100, 200 in the three input cycles, then 0. One output `rq(300)`, shift=2 → 75.
- `in_sum`=14'h1800 (guard 01) → `pre_output`=4095. `in_sum`=14'h2000 (guard 10) → `pre_output`=−4096. passes=2 for both cases.
- Requant signs:
  - relu=1, final −50 → 0.
  - relu=0, shift=1, −5 → −2.
  - relu=0, shift=0, −300 → −128.
- Backpressure: passes=1, `out_ready`=0, three inputs 10, 20, 30. Expect `in_ready`=0 on the third. Then raise `out_ready` → outputs 10, 20, 30 in order, with no loss or duplication.
- Reset mid-window: passes=4, two inputs accepted, then `reset`=0 for one cycle → `pre_output`=0, `out_valid`=0, `busy`=0. The next window of 4 produces exactly one output.

Source files
------------

// File: rtl/npu_acc_pkg.sv
// Shared types and constants for the accumulation stage after adder_final.
package npu_acc_pkg;
  localparam int SUM_W = 14;
  localparam int ACC_W = 13;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(4095);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-4096);

  typedef enum logic {IDLE, ACCUM} acc_state_e;

  // Guard bits 01/10 mean the tree overflowed the 13-bit range in that direction.
  function automatic logic signed [ACC_W-1:0] sat14to13(input logic [SUM_W-1:0] s);
    case (s[SUM_W-1:SUM_W-2])
      2'b01:   return ACC_MAX;
      2'b10:   return ACC_MIN;
      default: return s[ACC_W-1:0];
    endcase
  endfunction
endpackage

// File: rtl/acc_out_fifo.sv
// Two-entry in-order valid/ready buffer; entry 0 is always the head.
module acc_out_fifo #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         full_o
);
  logic [1:0]   cnt_q;
  logic [W-1:0] mem0_q, mem1_q;
  logic         pop;

  assign valid_o = (cnt_q != 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign data_o  = mem0_q;
  assign pop     = valid_o & ready_i;

  // Shift-register style storage: pops move entry 1 forward, pushes fill the tail.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= 2'd0;
      mem0_q <= '0;
      mem1_q <= '0;
    end else begin
      case ({push_i, pop})
        2'b10: begin
          if (cnt_q == 2'd0) mem0_q <= data_i;
          else               mem1_q <= data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          mem0_q <= mem1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) mem0_q <= data_i;
          else begin
            mem0_q <= mem1_q;
            mem1_q <= data_i;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/accumulation_control.sv
// Saturates adder_final, feeds the partial sum back over a window of passes,
// then requantizes the window result into the output buffer.
module accumulation_control
  import npu_acc_pkg::*;
#(
  parameter int PASS_W = 4,
  parameter int OUT_W  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [PASS_W-1:0]        cfg_passes_i,
  input  logic [3:0]               cfg_shift_i,
  input  logic                     cfg_relu_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [SUM_W-1:0]         in_sum_i,
  output logic signed [ACC_W-1:0]  pre_output_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [OUT_W-1:0]  out_data_o,
  output logic                     busy_o
);
  localparam logic signed [SUM_W-1:0] Q_MAX = SUM_W'(2**(OUT_W-1) - 1);
  localparam logic signed [SUM_W-1:0] Q_MIN = SUM_W'(-(2**(OUT_W-1)));

  acc_state_e               state_q;
  logic [PASS_W-1:0]        pass_cnt_q, passes_l_q;
  logic [3:0]               shift_l_q;
  logic                     relu_l_q;

  logic                     first;
  logic [PASS_W-1:0]        passes_cur;
  logic [3:0]               shift_cur;
  logic                     relu_cur;
  logic                     is_final, accept, push, fifo_full;
  logic signed [ACC_W-1:0]  sat_val;
  logic signed [SUM_W-1:0]  rq_x, rq_sh;
  logic [OUT_W-1:0]         rq_val;

  // On pass 0 the live cfg inputs govern; later passes use the latched copy.
  always_comb begin
    first      = (pass_cnt_q == '0);
    passes_cur = passes_l_q;
    shift_cur  = shift_l_q;
    relu_cur   = relu_l_q;
    if (first) begin
      passes_cur = (cfg_passes_i == '0) ? PASS_W'(1) : cfg_passes_i;
      shift_cur  = cfg_shift_i;
      relu_cur   = cfg_relu_i;
    end
    is_final = (pass_cnt_q == passes_cur - PASS_W'(1));
  end

  assign in_ready_o = ~is_final | ~fifo_full;
  assign accept     = in_valid_i & in_ready_o;
  assign push       = accept & is_final;
  assign sat_val    = sat14to13(in_sum_i);
  assign busy_o     = (state_q == ACCUM) | out_valid_o;

  // Requantize: optional ReLU, round-half-up arithmetic shift, clamp to OUT_W.
  always_comb begin
    rq_x = {sat_val[ACC_W-1], sat_val};
    if (relu_cur && sat_val[ACC_W-1]) rq_x = '0;
    if (shift_cur != 4'd0) rq_x = rq_x + (SUM_W'(1) <<< (shift_cur - 4'd1));
    rq_sh = rq_x >>> shift_cur;
    if (rq_sh > Q_MAX)      rq_val = Q_MAX[OUT_W-1:0];
    else if (rq_sh < Q_MIN) rq_val = Q_MIN[OUT_W-1:0];
    else                    rq_val = rq_sh[OUT_W-1:0];
  end

  // Window FSM, pass counter, config latch and feedback register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      pass_cnt_q   <= '0;
      passes_l_q   <= PASS_W'(1);
      shift_l_q    <= 4'd0;
      relu_l_q     <= 1'b0;
      pre_output_o <= '0;
    end else if (accept) begin
      if (first) begin
        passes_l_q <= passes_cur;
        shift_l_q  <= cfg_shift_i;
        relu_l_q   <= cfg_relu_i;
      end
      if (is_final) begin
        state_q      <= IDLE;
        pass_cnt_q   <= '0;
        pre_output_o <= '0;
      end else begin
        state_q      <= ACCUM;
        pass_cnt_q   <= pass_cnt_q + 1'b1;
        pre_output_o <= sat_val;
      end
    end
  end

  acc_out_fifo #(.W(OUT_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (rq_val),
    .ready_i (out_ready_i),
    .valid_o (out_valid_o),
    .data_o  (out_data_o),
    .full_o  (fifo_full)
  );
endmodule

// File: tb/tb_accumulation_control.sv
// Randomized + directed bench with a window-level reference model and output scoreboard.
module tb_accumulation_control;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [3:0]         cfg_passes = 4'd1;
  logic [3:0]         cfg_shift = 4'd0;
  logic               cfg_relu = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [13:0]        in_sum = '0;
  logic signed [12:0] pre_output;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [7:0]  out_data;
  logic               busy;

  accumulation_control #(.PASS_W(4), .OUT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_passes_i(cfg_passes), .cfg_shift_i(cfg_shift),
    .cfg_relu_i(cfg_relu), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_sum_i(in_sum),
    .pre_output_o(pre_output), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, n_out = 0;
  int exp_q[$];
  // model state: position within the window, latched config, expected feedback
  int m_pass = 0, m_np = 1, m_sh = 0, m_pre = 0;
  bit m_rl = 0, m_open = 0;
  int np, sh, s;
  bit rl, fin, exp_rdy;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int sat_m(input logic [13:0] x);
    logic signed [13:0] sx;
    sx = x;
    return clamp(int'(sx), -4096, 4095);
  endfunction

  function automatic int rq_m(input int v, input int shf, input bit relu);
    int t;
    t = (relu && v < 0) ? 0 : v;
    if (shf > 0) t = (t + (1 << (shf - 1))) >>> shf;
    return clamp(t, -128, 127);
  endfunction

  // Reference model + scoreboard, evaluated mid-cycle against the state after the last edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_pass = 0; m_pre = 0; m_open = 0;
      exp_q.delete();
      chk("rst_pre", int'(pre_output), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(in_ready), 1);
    end else begin
      np = (m_pass == 0) ? ((cfg_passes == 0) ? 1 : int'(cfg_passes)) : m_np;
      sh = (m_pass == 0) ? int'(cfg_shift) : m_sh;
      rl = (m_pass == 0) ? cfg_relu : m_rl;
      fin = (m_pass == np - 1);
      exp_rdy = !fin || (exp_q.size() < 2);
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      chk("pre_output", int'(pre_output), m_pre);
      chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      chk("busy", int'(busy), int'(m_open || exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_data", int'(out_data), exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        if (m_pass == 0) begin m_np = np; m_sh = sh; m_rl = rl; end
        s = sat_m(in_sum);
        if (fin) begin
          exp_q.push_back(rq_m(s, sh, rl));
          m_pass = 0; m_pre = 0; m_open = 0;
        end else begin
          m_pass++; m_pre = s; m_open = 1;
        end
      end
    end
  end

  // Present one input and hold it until accepted (bounded).
  task automatic send(input int v);
    int t;
    in_valid = 1'b1;
    in_sum = v[13:0];
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic cfg(input int p, input int shf, input bit r);
    cfg_passes = p[3:0];
    cfg_shift = shf[3:0];
    cfg_relu = r;
  endtask

  int base;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // single-pass windows
    cfg(1, 0, 0);
    send(256);
    chk("d256_s0", int'(out_data), 127);
    chk("d256_pre", int'(pre_output), 0);
    cfg(1, 2, 0);
    send(256);
    @(negedge clk);
    chk("d256_s2", int'(out_data), 64);
    @(posedge clk); #1;

    // three-pass window with feedback
    cfg(3, 2, 0);
    send(100);
    chk("pre_100", int'(pre_output), 100);
    send(200);
    chk("pre_200", int'(pre_output), 200);
    send(300);
    chk("pre_fin", int'(pre_output), 0);
    chk("rq300", int'(out_data), 75);
    repeat (2) @(posedge clk); #1;

    // guard-bit saturation
    cfg(2, 0, 0);
    send(14'h1800);
    chk("sat_pos", int'(pre_output), 4095);
    send(0);
    send(14'h2000);
    chk("sat_neg", int'(pre_output), -4096);
    send(0);
    repeat (2) @(posedge clk); #1;

    // requant signs
    cfg(1, 0, 1); send(-50); chk("relu_neg", int'(out_data), 0);
    @(posedge clk); #1;
    cfg(1, 1, 0); send(-5); chk("rnd_neg", int'(out_data), -2);
    @(posedge clk); #1;
    cfg(1, 0, 0); send(-300); chk("clamp_neg", int'(out_data), -128);
    repeat (2) @(posedge clk); #1;

    // backpressure
    base = n_out;
    out_ready = 1'b0;
    cfg(1, 0, 0);
    send(10);
    send(20);
    in_valid = 1'b1; in_sum = 14'd30;
    @(negedge clk);
    chk("bp_ready", int'(in_ready), 0);
    @(posedge clk); #1 out_ready = 1'b1;
    send(30);
    repeat (4) @(posedge clk); #1;
    chk("bp_count", n_out - base, 3);

    // reset in the middle of a window with a pending result
    cfg(1, 0, 0);
    out_ready = 1'b0;
    send(7);
    cfg(4, 0, 0);
    send(11);
    send(12);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_pre", int'(pre_output), 0);
    chk("mr_valid", int'(out_valid), 0);
    chk("mr_busy", int'(busy), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    base = n_out;
    send(1); send(2); send(3); send(4);
    repeat (3) @(posedge clk); #1;
    chk("mr_count", n_out - base, 1);

    // randomized traffic, including mid-window config changes
    for (int i = 0; i < 600; i++) begin
      cfg_passes = 4'($urandom_range(0, 4));
      cfg_shift = 4'($urandom_range(0, 12));
      cfg_relu = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: in_sum = 14'($urandom_range(0, 600));
        1: in_sum = 14'(-int'($urandom_range(0, 600)));
        default: in_sum = 14'($urandom);
      endcase
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("drain_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
